// File: rtl/mem_access.sv
// mem_access: pipeline memory stage, single-outstanding req/ack data bus.
// Optional MEM_ALIGN_CHECK_EN: misaligned halfword/word accesses raise exc_adel/exc_ades.
module mem_access (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  mem_wd,
  input  logic        mem_wreg,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_op,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_sdata,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_sel,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        stallreq,
  output logic [4:0]  wb_wd,
  output logic        wb_wreg,
  output logic [31:0] wb_wdata,
  output logic        exc_adel,
  output logic        exc_ades
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_t;

  state_t      state_q, state_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;

  logic        is_ld, is_st, sz_b, sz_h, sz_w, misal;
  logic [3:0]  sel_c;
  logic [31:0] wdata_c, ld_val;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Decode op into direction and access size.
  always_comb begin
    is_ld = 1'b0;
    is_st = 1'b0;
    sz_b  = 1'b0;
    sz_h  = 1'b0;
    sz_w  = 1'b0;
    case (mem_op)
      4'd1, 4'd2: begin is_ld = 1'b1; sz_b = 1'b1; end
      4'd3, 4'd4: begin is_ld = 1'b1; sz_h = 1'b1; end
      4'd5:       begin is_ld = 1'b1; sz_w = 1'b1; end
      4'd6:       begin is_st = 1'b1; sz_b = 1'b1; end
      4'd7:       begin is_st = 1'b1; sz_h = 1'b1; end
      4'd8:       begin is_st = 1'b1; sz_w = 1'b1; end
      default:    ;
    endcase
  end

  // Misalignment detect; without the check, low bits are simply ignored.
  always_comb begin
`ifdef MEM_ALIGN_CHECK_EN
    misal = (sz_h && mem_addr[0]) ||
            (sz_w && (mem_addr[1:0] != 2'b00));
`else
    misal = 1'b0;
`endif
  end

  // Byte lanes and lane-replicated store data.
  always_comb begin
    sel_c   = 4'b1111;
    wdata_c = mem_sdata;
    if (sz_b) begin
      sel_c   = 4'b0001 << mem_addr[1:0];
      wdata_c = {4{mem_sdata[7:0]}};
    end else if (sz_h) begin
      sel_c   = mem_addr[1] ? 4'b1100 : 4'b0011;
      wdata_c = {2{mem_sdata[15:0]}};
    end
  end

  // Load value extraction from the captured read word.
  always_comb begin
    case (mem_addr[1:0])
      2'd0:    byte_v = rdata_q[7:0];
      2'd1:    byte_v = rdata_q[15:8];
      2'd2:    byte_v = rdata_q[23:16];
      default: byte_v = rdata_q[31:24];
    endcase
    half_v = mem_addr[1] ? rdata_q[31:16] : rdata_q[15:0];
    case (mem_op)
      4'd1:    ld_val = {{24{byte_v[7]}}, byte_v};
      4'd2:    ld_val = {24'b0, byte_v};
      4'd3:    ld_val = {{16{half_v[15]}}, half_v};
      4'd4:    ld_val = {16'b0, half_v};
      default: ld_val = rdata_q;
    endcase
  end

  // Access FSM: next state, bus register loads, stage outputs.
  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    we_d     = we_q;
    addr_d   = addr_q;
    sel_d    = sel_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    stallreq = 1'b0;
    wb_wd    = mem_wd;
    wb_wreg  = mem_wreg;
    wb_wdata = mem_wdata;
    exc_adel = 1'b0;
    exc_ades = 1'b0;
    case (state_q)
      IDLE: begin
        if (is_ld || is_st) begin
          wb_wreg = 1'b0;
          if (misal) begin
            exc_adel = is_ld;
            exc_ades = is_st;
          end else begin
            stallreq = 1'b1;
            state_d  = WAIT;
            req_d    = 1'b1;
            we_d     = is_st;
            addr_d   = {mem_addr[31:2], 2'b00};
            sel_d    = sel_c;
            wdata_d  = wdata_c;
          end
        end
      end
      WAIT: begin
        stallreq = 1'b1;
        wb_wreg  = 1'b0;
        if (bus_ack) begin
          rdata_d = bus_rdata;
          req_d   = 1'b0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (is_ld) wb_wdata = ld_val;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (rst) begin
      stallreq = 1'b0;
      wb_wd    = 5'd0;
      wb_wreg  = 1'b0;
      wb_wdata = 32'd0;
      exc_adel = 1'b0;
      exc_ades = 1'b0;
    end
  end

  // State and bus registers, synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      sel_q   <= 4'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      sel_q   <= sel_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign bus_req   = req_q;
  assign bus_we    = we_q;
  assign bus_addr  = addr_q;
  assign bus_sel   = sel_q;
  assign bus_wdata = wdata_q;

endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: table vectors, corner sequences and random ops
// against an arithmetic reference model of the memory stage.
module tb_mem_access;

  localparam logic [3:0] LB  = 4'd1;
  localparam logic [3:0] LBU = 4'd2;
  localparam logic [3:0] LH  = 4'd3;
  localparam logic [3:0] LHU = 4'd4;
  localparam logic [3:0] LW  = 4'd5;
  localparam logic [3:0] SB  = 4'd6;
  localparam logic [3:0] SH  = 4'd7;
  localparam logic [3:0] SW  = 4'd8;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_op;
  logic [31:0] mem_addr;
  logic [31:0] mem_sdata;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_sel;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic        stallreq;
  logic [4:0]  wb_wd;
  logic        wb_wreg;
  logic [31:0] wb_wdata;
  logic        exc_adel;
  logic        exc_ades;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_access dut (
    .clk(clk), .rst(rst),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg),
    .mem_wdata(mem_wdata), .mem_op(mem_op),
    .mem_addr(mem_addr), .mem_sdata(mem_sdata),
    .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_sel(bus_sel),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .bus_ack(bus_ack), .stallreq(stallreq),
    .wb_wd(wb_wd), .wb_wreg(wb_wreg),
    .wb_wdata(wb_wdata), .exc_adel(exc_adel),
    .exc_ades(exc_ades)
  );

  typedef struct {
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] rdata;
    int          waits;
    bit          idle_ack;
    logic [3:0]  sel;
    logic [31:0] wdata;
    logic [31:0] wb;
  } vec_t;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  // Reference model: plain arithmetic on the access rules.
  function automatic int op_size(input logic [3:0] op);
    if (op == LB || op == LBU || op == SB) return 1;
    if (op == LH || op == LHU || op == SH) return 2;
    if (op == LW || op == SW) return 4;
    return 0;
  endfunction

  function automatic bit is_store(input logic [3:0] op);
    return op >= SB && op <= SW;
  endfunction

  function automatic bit m_misal(input logic [3:0] op,
                                 input logic [31:0] a);
`ifdef MEM_ALIGN_CHECK_EN
    int sz = op_size(op);
    return (sz == 2 && a % 2 != 0) || (sz == 4 && a % 4 != 0);
`else
    return (op == 4'd15) && (a != a);
`endif
  endfunction

  function automatic logic [3:0] m_sel(input logic [3:0] op,
                                       input logic [31:0] a);
    int sz = op_size(op);
    if (sz == 1) return 4'(1 << (a % 4));
    if (sz == 2) return ((a / 2) % 2 == 1) ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [3:0] op,
                                          input logic [31:0] s);
    int sz = op_size(op);
    if (sz == 1) return (s & 32'hFF) * 32'h01010101;
    if (sz == 2) return (s & 32'hFFFF) * 32'h00010001;
    return s;
  endfunction

  function automatic logic [31:0] m_load(input logic [3:0] op,
                                         input logic [31:0] a,
                                         input logic [31:0] r);
    logic [31:0] v;
    if (op == LB || op == LBU) begin
      v = (r >> (8 * (a % 4))) & 32'hFF;
      if (op == LB && v >= 128) v = v - 32'd256;
    end else if (op == LH || op == LHU) begin
      v = (r >> (16 * ((a / 2) % 2))) & 32'hFFFF;
      if (op == LH && v >= 32768) v = v - 32'd65536;
    end else begin
      v = r;
    end
    return v;
  endfunction

  // Full access: called just after a rising edge with the stage idle.
  task automatic run_mem(input vec_t v);
    logic [4:0]  wd;
    logic        wr;
    logic [31:0] wdt;
    bit          st;
    st = is_store(v.op);
    wd = 5'($urandom);
    wr = 1'($urandom);
    wdt = $urandom;
    mem_op = v.op;
    mem_addr = v.addr;
    mem_sdata = v.sdata;
    mem_wd = wd;
    mem_wreg = wr;
    mem_wdata = wdt;
    if (v.idle_ack) begin
      bus_ack = 1'b1;
      bus_rdata = ~v.rdata;
    end
    @(negedge clk);
    chk("idle_stall", 32'(stallreq), 32'd1);
    chk("idle_wreg", 32'(wb_wreg), 32'd0);
    chk("idle_req", 32'(bus_req), 32'd0);
    @(posedge clk);
    #1 bus_ack = 1'b0;
    for (int k = 0; k <= v.waits; k++) begin
      @(negedge clk);
      if (k == 0) begin
        chk("bus_we", 32'(bus_we), 32'(st));
        chk("bus_addr", bus_addr, v.addr & ~32'd3);
        chk("bus_sel", 32'(bus_sel), 32'(v.sel));
        if (st) chk("bus_wdata", bus_wdata, v.wdata);
      end
      chk("wait_stall", 32'(stallreq), 32'd1);
      chk("wait_wreg", 32'(wb_wreg), 32'd0);
      chk("wait_req", 32'(bus_req), 32'd1);
      if (k == v.waits) begin
        bus_ack = 1'b1;
        bus_rdata = v.rdata;
      end else begin
        bus_rdata = $urandom;
      end
      @(posedge clk);
      #1 bus_ack = 1'b0;
      bus_rdata = $urandom;
    end
    chk("req_fall", 32'(bus_req), 32'd0);
    @(negedge clk);
    chk("done_stall", 32'(stallreq), 32'd0);
    chk("done_wd", 32'(wb_wd), 32'(wd));
    chk("done_wreg", 32'(wb_wreg), 32'(wr));
    chk("done_wdata", wb_wdata, st ? wdt : v.wb);
    @(posedge clk);
    #1 mem_op = 4'd0;
  endtask

  // Non-memory op passes straight through in the same cycle.
  task automatic run_pass(input logic [3:0] op);
    logic [4:0]  wd;
    logic        wr;
    logic [31:0] wdt;
    wd = 5'($urandom);
    wr = 1'($urandom);
    wdt = $urandom;
    mem_op = op;
    mem_wd = wd;
    mem_wreg = wr;
    mem_wdata = wdt;
    mem_addr = $urandom;
    @(negedge clk);
    chk("pass_stall", 32'(stallreq), 32'd0);
    chk("pass_wd", 32'(wb_wd), 32'(wd));
    chk("pass_wreg", 32'(wb_wreg), 32'(wr));
    chk("pass_wdata", wb_wdata, wdt);
    chk("pass_exc", 32'({exc_adel, exc_ades}), 32'd0);
    @(posedge clk);
    #1 mem_op = 4'd0;
  endtask

  task automatic run_misal(input logic [3:0] op,
                           input logic [31:0] a);
    bit st;
    st = is_store(op);
    mem_op = op;
    mem_addr = a;
    mem_wreg = 1'b1;
    @(negedge clk);
    chk("mis_adel", 32'(exc_adel), 32'(!st));
    chk("mis_ades", 32'(exc_ades), 32'(st));
    chk("mis_stall", 32'(stallreq), 32'd0);
    chk("mis_wreg", 32'(wb_wreg), 32'd0);
    @(posedge clk);
    #1 chk("mis_req", 32'(bus_req), 32'd0);
    mem_op = 4'd0;
  endtask

  function automatic vec_t mk(input logic [3:0] op,
                              input logic [31:0] a,
                              input logic [31:0] s,
                              input logic [31:0] r,
                              input int w, input bit ia);
    vec_t v;
    v.op = op;
    v.addr = a;
    v.sdata = s;
    v.rdata = r;
    v.waits = w;
    v.idle_ack = ia;
    v.sel = m_sel(op, a);
    v.wdata = m_wdata(op, s);
    v.wb = m_load(op, a, r);
    return v;
  endfunction

  vec_t tbl[9];

  initial begin
    tbl[0] = '{LB,  32'h103, 32'h0, 32'h80FFFFFF, 0, 1'b0,
               4'h8, 32'h0, 32'hFFFFFF80};
    tbl[1] = '{LBU, 32'h103, 32'h0, 32'h80FFFFFF, 0, 1'b0,
               4'h8, 32'h0, 32'h00000080};
    tbl[2] = '{SH,  32'h22, 32'hAAAABEEF, 32'h0, 2, 1'b0,
               4'hC, 32'hBEEFBEEF, 32'h0};
    tbl[3] = '{LW,  32'h40, 32'h0, 32'h12345678, 1, 1'b1,
               4'hF, 32'h0, 32'h12345678};
    tbl[4] = '{LH,  32'h12, 32'h0, 32'h80017FFF, 0, 1'b0,
               4'hC, 32'h0, 32'hFFFF8001};
    tbl[5] = '{LHU, 32'h10, 32'h0, 32'h8001F00D, 0, 1'b0,
               4'h3, 32'h0, 32'h0000F00D};
    tbl[6] = '{SB,  32'h201, 32'h0000005A, 32'h0, 1, 1'b0,
               4'h2, 32'h5A5A5A5A, 32'h0};
    tbl[7] = '{SW,  32'h300, 32'hDEADBEEF, 32'h0, 0, 1'b0,
               4'hF, 32'hDEADBEEF, 32'h0};
    tbl[8] = '{LB,  32'h101, 32'h0, 32'h11227F33, 0, 1'b0,
               4'h2, 32'h0, 32'h0000007F};

    rst = 1'b1;
    mem_op = 4'd0;
    mem_wd = 5'd7;
    mem_wreg = 1'b1;
    mem_wdata = 32'h55AA55AA;
    mem_addr = 32'h0;
    mem_sdata = 32'h0;
    bus_rdata = 32'h0;
    bus_ack = 1'b0;

    @(negedge clk);
    chk("rst_stall", 32'(stallreq), 32'd0);
    chk("rst_wd", 32'(wb_wd), 32'd0);
    chk("rst_wreg", 32'(wb_wreg), 32'd0);
    chk("rst_wdata", wb_wdata, 32'd0);
    chk("rst_req", 32'(bus_req), 32'd0);
    chk("rst_we", 32'(bus_we), 32'd0);
    chk("rst_addr", bus_addr, 32'd0);
    chk("rst_sel", 32'(bus_sel), 32'd0);
    chk("rst_bwdata", bus_wdata, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    mem_op = 4'd0;
    mem_wd = 5'd5;
    mem_wreg = 1'b1;
    mem_wdata = 32'h1234;
    @(negedge clk);
    chk("tp_wd", 32'(wb_wd), 32'd5);
    chk("tp_wreg", 32'(wb_wreg), 32'd1);
    chk("tp_wdata", wb_wdata, 32'h1234);
    chk("tp_stall", 32'(stallreq), 32'd0);
    @(posedge clk);
    #1;
    run_pass(4'd9);
    run_pass(4'd15);

    for (int i = 0; i < 9; i++) run_mem(tbl[i]);

    // Reset while waiting for ack abandons the access.
    mem_op = LW;
    mem_addr = 32'h80;
    mem_wd = 5'd3;
    mem_wreg = 1'b1;
    mem_wdata = 32'hCAFE0001;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("rw_req", 32'(bus_req), 32'd1);
    rst = 1'b1;
    #1;
    chk("rw_stall", 32'(stallreq), 32'd0);
    chk("rw_wd", 32'(wb_wd), 32'd0);
    chk("rw_wreg", 32'(wb_wreg), 32'd0);
    chk("rw_wdata", wb_wdata, 32'd0);
    @(posedge clk);
    #1 chk("rw_req_clr", 32'(bus_req), 32'd0);
    mem_op = 4'd0;
    rst = 1'b0;
    @(negedge clk);
    chk("rw_idle", 32'(stallreq), 32'd0);
    chk("rw_pass", 32'(wb_wreg), 32'd1);
    @(posedge clk);
    #1;
    run_mem(mk(LW, 32'h84, 32'h0, 32'hA5A5_0F0F, 1, 1'b0));

`ifdef MEM_ALIGN_CHECK_EN
    run_misal(LW, 32'h102);
    run_misal(SH, 32'h21);
    run_misal(LHU, 32'h33);
    run_misal(SW, 32'h202);
`else
    run_mem(mk(LW, 32'h102, 32'h0, 32'h0BADF00D, 0, 1'b0));
    run_mem(mk(SH, 32'h21, 32'h1234ABCD, 32'h0, 0, 1'b0));
`endif

    for (int i = 0; i < 60; i++) begin
      logic [3:0]  op;
      logic [31:0] a;
      op = 4'($urandom_range(0, 15));
      a = $urandom;
      if (op_size(op) == 0) run_pass(op);
      else if (m_misal(op, a)) run_misal(op, a);
      else run_mem(mk(op, a, $urandom, $urandom,
                      $urandom_range(0, 3),
                      1'($urandom_range(0, 1))));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=%0d want=0", bad);
    $fatal(1, "timeout");
  end

endmodule
